// File: rtl/uart_rx_packer_pkg.sv
// Shared defines for the UART receive packer: system counts, default sizing and FSM encoding.
// Also holds the longest message, in bytes, that still fits the 8-bit word count.
package uart_rx_packer_pkg;

  localparam int NUM_SOURCES = 1;
  localparam int NUM_UART    = 1;

  localparam int DEF_IDLE_CYCLES = 4340;
  localparam int DEF_WORD_DEPTH  = 256;
  localparam int DEF_DESC_DEPTH  = 4;

  // 255 words of two bytes each
  localparam int MAX_MSG_BYTES = 510;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2,
    DROP    = 2'd3
  } pack_state_e;

endpackage

// File: rtl/uart_rx_packer_ram.sv
// Simple dual-port word RAM with registered read.
// A write to the address being read is forwarded, so a word flushed at commit is visible on the next cycle.
module packer_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                            rdata_q <= '0;
    else if (we_i && waddr_i == raddr_i)  rdata_q <= wdata_i;
    else                                  rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_rx_packer.sv
// Packs UART bytes into 16-bit words, frames messages on idle gaps and hands the consumer
// only committed messages through a word RAM plus a register-based descriptor queue.
module uart_rx_packer
  import uart_rx_packer_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int WORD_DEPTH  = DEF_WORD_DEPTH,
  parameter int DESC_DEPTH  = DEF_DESC_DEPTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_valid_i,
  input  logic        rd_req_i,
  input  logic        msg_start_i,
  output logic [15:0] fifo_q_o,
  output logic        got_full_msg_o,
  output logic [7:0]  msg_len_o,
  output logic        parity_out_o,
  output logic        overflow_o
);

  localparam int AW = $clog2(WORD_DEPTH);
  localparam int DA = $clog2(DESC_DEPTH);
  localparam int GW = $clog2(IDLE_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_CYCLES - 1);
  localparam logic [8:0]    LAST_BYTE_CNT = 9'(MAX_MSG_BYTES - 1);

  pack_state_e   state_q, state_d;
  logic [7:0]    hi_q, hi_d;
  logic [8:0]    byte_cnt_q, byte_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   cptr_q, cptr_d;
  logic [AW:0]   rptr_q;
  logic          ovf_q, ovf_d;
  logic [DA:0]   dhead_q, dtail_q;
  logic [7:0]    desc_len_q [DESC_DEPTH];
  logic          desc_par_q [DESC_DEPTH];

  logic          ram_we;
  logic [15:0]   ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [15:0]   ram_q;
  logic          desc_push;

  logic ram_full, desc_full, desc_empty, words_avail, rd_pop, desc_pop;
  logic [7:0] commit_len;

  assign ram_full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign desc_full   = (dtail_q[DA] != dhead_q[DA]) && (dtail_q[DA-1:0] == dhead_q[DA-1:0]);
  assign desc_empty  = (dtail_q == dhead_q);
  assign words_avail = (cptr_q != rptr_q);
  assign rd_pop      = rd_req_i && words_avail;
  assign desc_pop    = msg_start_i && !desc_empty;
  assign commit_len  = 8'((byte_cnt_q + 9'd1) >> 1);
  assign ram_raddr   = rd_pop ? rptr_q[AW-1:0] + AW'(1) : rptr_q[AW-1:0];

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    byte_cnt_d = byte_cnt_q;
    gap_d      = gap_q;
    wptr_d     = wptr_q;
    cptr_d     = cptr_q;
    ovf_d      = ovf_q;
    ram_we     = 1'b0;
    ram_wdata  = 16'h0000;
    desc_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_valid_i) begin
          hi_d       = rx_byte_i;
          byte_cnt_d = 9'd1;
          gap_d      = '0;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_valid_i) begin
          gap_d      = '0;
          byte_cnt_d = byte_cnt_q + 9'd1;
          if (!byte_cnt_q[0]) begin
            hi_d = rx_byte_i;
          end else if (ram_full) begin
            state_d = DROP;
            wptr_d  = cptr_q;
            ovf_d   = 1'b1;
          end else begin
            ram_we    = 1'b1;
            ram_wdata = {hi_q, rx_byte_i};
            wptr_d    = wptr_q + (AW+1)'(1);
            if (byte_cnt_q == LAST_BYTE_CNT) state_d = COMMIT;
          end
        end else if (gap_q == GAP_LAST) begin
          state_d = COMMIT;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      COMMIT: begin
        // A flush that cannot fit is treated like a full descriptor queue
        if (desc_full || (byte_cnt_q[0] && ram_full)) begin
          state_d = DROP;
          wptr_d  = cptr_q;
          ovf_d   = 1'b1;
          gap_d   = '0;
        end else begin
          desc_push = 1'b1;
          if (byte_cnt_q[0]) begin
            ram_we    = 1'b1;
            ram_wdata = {hi_q, 8'h00};
            wptr_d    = wptr_q + (AW+1)'(1);
          end
          cptr_d  = wptr_d;
          state_d = IDLE;
          if (rx_valid_i) begin
            hi_d       = rx_byte_i;
            byte_cnt_d = 9'd1;
            gap_d      = '0;
            state_d    = COLLECT;
          end
        end
      end
      DROP: begin
        if (rx_valid_i)              gap_d   = '0;
        else if (gap_q == GAP_LAST)  state_d = IDLE;
        else                         gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      byte_cnt_q <= '0;
      gap_q      <= '0;
      wptr_q     <= '0;
      cptr_q     <= '0;
      rptr_q     <= '0;
      ovf_q      <= 1'b0;
      dhead_q    <= '0;
      dtail_q    <= '0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      byte_cnt_q <= byte_cnt_d;
      gap_q      <= gap_d;
      wptr_q     <= wptr_d;
      cptr_q     <= cptr_d;
      ovf_q      <= ovf_d;
      if (rd_pop)    rptr_q  <= rptr_q + (AW+1)'(1);
      if (desc_push) dtail_q <= dtail_q + (DA+1)'(1);
      if (desc_pop)  dhead_q <= dhead_q + (DA+1)'(1);
    end
  end

  // Descriptor payload needs no reset; the head/tail pointers decide what is valid
  always_ff @(posedge clk_i) begin
    if (desc_push) begin
      desc_len_q[dtail_q[DA-1:0]] <= commit_len;
      desc_par_q[dtail_q[DA-1:0]] <= byte_cnt_q[0];
    end
  end

  packer_ram #(.DEPTH(WORD_DEPTH), .WIDTH(16)) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (ram_we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_q)
  );

  assign fifo_q_o       = words_avail ? ram_q : 16'h0000;
  assign got_full_msg_o = !desc_empty;
  assign msg_len_o      = desc_empty ? 8'h00 : desc_len_q[dhead_q[DA-1:0]];
  assign parity_out_o   = desc_empty ? 1'b0 : desc_par_q[dhead_q[DA-1:0]];
  assign overflow_o     = ovf_q;

endmodule
